// File: rtl/rs_encoder_pkg.sv
// rtl/rs_encoder_pkg.sv - RS(255,247) encoder constants, generator coefficients and state type
package rs_encoder_pkg;

    localparam int N    = 255;
    localparam int K    = 247;
    localparam int NPAR = N - K;

    localparam logic [8:0] PRIM_POLY = 9'h11D;

    // g(x) = prod_{i=1..8} (x + alpha^i), non-leading coefficients
    localparam logic [7:0] G0 = 8'h25;
    localparam logic [7:0] G1 = 8'hE0;
    localparam logic [7:0] G2 = 8'h08;
    localparam logic [7:0] G3 = 8'hAC;
    localparam logic [7:0] G4 = 8'h47;
    localparam logic [7:0] G5 = 8'hB2;
    localparam logic [7:0] G6 = 8'h2C;
    localparam logic [7:0] G7 = 8'hE3;

    localparam logic [NPAR-1:0][7:0] GEN_COEFS = {G7, G6, G5, G4, G3, G2, G1, G0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY
    } enc_state_e;

endpackage

// File: rtl/rs_encoder_if.sv
// rtl/rs_encoder_if.sv - message-in / codeword-out handshake bundle for rs_encoder
interface rs_encoder_if;

    logic       start;
    logic       din_valid;
    logic [7:0] din;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout;
    logic       dout_sop;
    logic       dout_eop;
    logic       busy;

    modport slave (
        input  start, din_valid, din,
        output din_ready, dout_valid, dout, dout_sop, dout_eop, busy
    );

    modport master (
        output start, din_valid, din,
        input  din_ready, dout_valid, dout, dout_sop, dout_eop, busy
    );

endinterface

// File: rtl/rs_encoder_gf256mul.sv
// rtl/rs_encoder_gf256mul.sv - combinational GF(2^8) multiplier over the package primitive polynomial
module gf256mul
    import rs_encoder_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] p_o
);

    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add: sh walks a_i * x^i, reduced modulo the primitive polynomial.
    always_comb begin
        acc = 8'h00;
        sh  = a_i;
        for (int i = 0; i < 8; i++) begin
            if (b_i[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ ({8{sh[7]}} & PRIM_POLY[7:0]);
        end
        p_o = acc;
    end

endmodule

// File: rtl/rs_encoder.sv
// rtl/rs_encoder.sv - systematic RS(255,247) encoder, LFSR parity with streamed codeword output
module rs_encoder
    import rs_encoder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    rs_encoder_if.slave  bus
);

    localparam logic [7:0] LAST_MSG = 8'(K - 1);
    localparam logic [2:0] LAST_PAR = 3'(NPAR - 1);

    enc_state_e                 state_q;
    logic [NPAR-1:0][7:0]       r_q;
    logic [7:0]                 cnt_q;
    logic [2:0]                 par_cnt_q;
    logic                       din_ready_q;
    logic                       dout_valid_q;
    logic [7:0]                 dout_q;
    logic                       sop_q;
    logic                       eop_q;
    logic                       busy_q;

    logic [7:0]                 fb;
    logic [7:0]                 prod [NPAR];

    assign fb = bus.din ^ r_q[NPAR-1];

    for (genvar gi = 0; gi < NPAR; gi++) begin : g_mul
        gf256mul u_mul (
            .a_i (fb),
            .b_i (GEN_COEFS[gi]),
            .p_o (prod[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            r_q          <= '0;
            cnt_q        <= 8'h00;
            par_cnt_q    <= 3'd0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= 8'h00;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            // start overrides everything, including a byte offered in the same cycle
            if (bus.start) begin
                state_q     <= ST_DATA;
                r_q         <= '0;
                cnt_q       <= 8'h00;
                par_cnt_q   <= 3'd0;
                din_ready_q <= 1'b1;
                busy_q      <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        din_ready_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                    ST_DATA: begin
                        if (bus.din_valid && din_ready_q) begin
                            dout_q       <= bus.din;
                            dout_valid_q <= 1'b1;
                            sop_q        <= (cnt_q == 8'h00);
                            r_q[0]       <= prod[0];
                            for (int i = 1; i < NPAR; i++) begin
                                r_q[i] <= r_q[i-1] ^ prod[i];
                            end
                            if (cnt_q == LAST_MSG) begin
                                state_q     <= ST_PARITY;
                                din_ready_q <= 1'b0;
                                par_cnt_q   <= 3'd0;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        dout_q       <= r_q[NPAR-1];
                        dout_valid_q <= 1'b1;
                        r_q          <= {r_q[NPAR-2:0], 8'h00};
                        if (par_cnt_q == LAST_PAR) begin
                            eop_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            par_cnt_q <= par_cnt_q + 3'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.dout_sop   = sop_q;
    assign bus.dout_eop   = eop_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rs_encoder.sv
// tb/tb_rs_encoder.sv - directed self-checking bench for rs_encoder
module tb_rs_encoder;
    import rs_encoder_pkg::*;

    logic clk;
    logic rst_n;

    rs_encoder_if bus ();

    rs_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] gexp [8] = '{8'h25, 8'hE0, 8'h08, 8'hAC, 8'h47, 8'hB2, 8'h2C, 8'hE3};
    logic [7:0] msg [K];

    logic [7:0] cap_data [$];
    logic       cap_sop  [$];
    logic       cap_eop  [$];

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.dout_valid) begin
            cap_data.push_back(bus.dout);
            cap_sop.push_back(bus.dout_sop);
            cap_eop.push_back(bus.dout_eop);
        end
    end

    task automatic clear_cap();
        cap_data.delete();
        cap_sop.delete();
        cap_eop.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic feed(input bit gaps, input int stop_at, input bit hold_valid);
        int idx = 0;
        int cyc = 0;
        while (idx < stop_at && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.din_valid = 1'b0;
            end else begin
                bus.din_valid = 1'b1;
                bus.din       = msg[idx];
                if (bus.din_ready) idx++;
            end
        end
        check_eq("feed_done", idx, stop_at);
        @(negedge clk);
        bus.din_valid = hold_valid;
        bus.din       = 8'hA5;
    endtask

    task automatic wait_eop();
        bit seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (bus.dout_valid && bus.dout_eop) begin
                seen = 1'b1;
                check_eq("busy_at_eop", int'(bus.busy), 1);
                @(negedge clk);
                check_eq("busy_after_eop", int'(bus.busy), 0);
                check_eq("valid_after_eop", int'(bus.dout_valid), 0);
            end
        end
        check_eq("eop_seen", int'(seen), 1);
        @(negedge clk);
    endtask

    // kind: 0 = all-zero parity, 1 = parity equals G7..G0, 2 = syndromes must vanish
    task automatic verify_cw(input int kind);
        int sop_n = 0, eop_n = 0, sop_at = -1, eop_at = -1;
        check_eq("cw_len", cap_data.size(), N);
        if (cap_data.size() == N) begin
            for (int i = 0; i < N; i++) begin
                if (cap_sop[i]) begin sop_n++; if (sop_at < 0) sop_at = i; end
                if (cap_eop[i]) begin eop_n++; if (eop_at < 0) eop_at = i; end
            end
            check_eq("sop_count", sop_n, 1);
            check_eq("sop_pos", sop_at, 0);
            check_eq("eop_count", eop_n, 1);
            check_eq("eop_pos", eop_at, N - 1);
            for (int i = 0; i < K; i++) check_eq("msg_byte", cap_data[i], msg[i]);
            if (kind == 0) begin
                for (int j = 0; j < NPAR; j++) check_eq("zero_parity", cap_data[K+j], 0);
            end else if (kind == 1) begin
                for (int j = 0; j < NPAR; j++) check_eq("gen_parity", cap_data[K+j], gexp[NPAR-1-j]);
            end else begin
                logic [7:0] aj = 8'h01;
                for (int j = 1; j <= NPAR; j++) begin
                    logic [7:0] s = 8'h00;
                    aj = gf_mul(aj, 8'h02);
                    for (int i = 0; i < N; i++) s = gf_mul(s, aj) ^ cap_data[i];
                    check_eq("syndrome", s, 0);
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_din_ready"},  int'(bus.din_ready), 0);
        check_eq({tag, "_busy"},       int'(bus.busy), 0);
        check_eq({tag, "_dout_valid"}, int'(bus.dout_valid), 0);
        check_eq({tag, "_dout"},       int'(bus.dout), 0);
        check_eq({tag, "_sop"},        int'(bus.dout_sop), 0);
        check_eq({tag, "_eop"},        int'(bus.dout_eop), 0);
    endtask

    initial begin
        int held;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");

        // idle after reset: din_valid without start produces nothing
        rst_n = 1'b1;
        bus.din_valid = 1'b1;
        bus.din = 8'h5A;
        repeat (10) @(negedge clk);
        check_eq("idle_no_output", cap_data.size(), 0);
        check_eq("idle_ready", int'(bus.din_ready), 0);
        check_eq("idle_busy", int'(bus.busy), 0);
        bus.din_valid = 1'b0;

        // all-zero message, contiguous
        foreach (msg[i]) msg[i] = 8'h00;
        clear_cap();
        pulse_start();
        check_eq("busy_after_start", int'(bus.busy), 1);
        feed(1'b0, K, 1'b0);
        wait_eop();
        verify_cw(0);

        // impulse in the last byte, din_valid held through parity
        msg[K-1] = 8'h01;
        clear_cap();
        pulse_start();
        feed(1'b0, K, 1'b1);
        check_eq("ready_in_parity", int'(bus.din_ready), 0);
        wait_eop();
        bus.din_valid = 1'b0;
        verify_cw(1);

        // random message with input gaps
        foreach (msg[i]) msg[i] = 8'($urandom);
        clear_cap();
        pulse_start();
        feed(1'b1, K, 1'b0);
        wait_eop();
        verify_cw(2);

        // abort at byte 100 with a colliding din, then a full new message
        foreach (msg[i]) msg[i] = 8'($urandom);
        clear_cap();
        pulse_start();
        feed(1'b0, 100, 1'b0);
        bus.din_valid = 1'b1;
        bus.din       = msg[100];
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.din_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort_len", cap_data.size(), 100);
        held = 0;
        foreach (cap_eop[i]) if (cap_eop[i]) held++;
        check_eq("abort_no_eop", held, 0);
        foreach (msg[i]) msg[i] = 8'($urandom);
        clear_cap();
        feed(1'b1, K, 1'b0);
        wait_eop();
        verify_cw(2);

        // reset while parity byte 3 is on dout
        foreach (msg[i]) msg[i] = 8'($urandom);
        clear_cap();
        pulse_start();
        feed(1'b0, K, 1'b0);
        repeat (4) @(negedge clk);
        check_eq("p3_valid", int'(bus.dout_valid), 1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        held = cap_data.size();
        bus.din_valid = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_reset_quiet", cap_data.size(), held);
        check_eq("post_reset_busy", int'(bus.busy), 0);
        bus.din_valid = 1'b0;

        // recovery after reset
        foreach (msg[i]) msg[i] = 8'($urandom);
        clear_cap();
        pulse_start();
        feed(1'b1, K, 1'b0);
        wait_eop();
        verify_cw(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_encoder.md
RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 Parameters: N, 255, codeword length in bytes; K, 247, message length in bytes; NPAR, 8, parity bytes (N-K).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  single-cycle pulse; begins a new codeword and aborts any codeword in progress.
REQ-005 din_valid  input  1  din carries a message byte this cycle.
REQ-006 din  input  8  message byte, highest-degree coefficient first.
REQ-007 din_ready  output  1  high while the block accepts message bytes.
REQ-008 dout_valid  output  1  dout carries a codeword byte.
REQ-009 dout  output  8  codeword byte: K message bytes, then NPAR parity bytes.
REQ-010 dout_sop  output  1  high with the first message byte of a codeword.
REQ-011 dout_eop  output  1  high with the last parity byte.
REQ-012 busy  output  1  high from start until the cycle after the eop byte.

Function
REQ-013 Field: GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D) and alpha = 0x02.
REQ-014 Generator: g(x) = product over i = 1..8 of (x + alpha^i), monic; G0..G7 are the non-leading coefficients.
REQ-015 Code: systematic; parity = (m(x)·x^8) mod g(x).
REQ-016 States: IDLE, DATA, PARITY.
REQ-017 IDLE -> DATA on start; DATA -> PARITY when byte K is accepted; PARITY -> IDLE after the 8th parity byte is emitted.
REQ-018 start in any state: clear the parity registers R0..R7, clear the byte counter, and enter DATA.
REQ-019 din_ready = 1 only in DATA.
REQ-020 A byte is accepted when din_valid and din_ready are both high; gaps are allowed, and din_valid is ignored outside DATA.
REQ-021 On each accepted byte, with fb = din ^ R7: Ri <= R(i-1) ^ fb·Gi for i = 1..7, and R0 <= fb·G0.
REQ-022 Each accepted byte appears on dout exactly 1 cycle later with dout_valid = 1; dout_sop = 1 for byte 0.
REQ-023 In PARITY, emit R7 first and R0 last on 8 consecutive cycles, shifting R left with zero fill.
REQ-024 The first parity byte follows the last message byte on the next cycle, so there is no bubble.
REQ-025 dout_eop = 1 with R0.
REQ-026 The 8-bit byte counter runs 0..K-1 and never wraps within a codeword.
REQ-027 dout_valid, dout_sop and dout_eop are single-cycle per byte; outputs are registered.
REQ-028 start coinciding with an accepted din: start wins, and that din byte is not encoded.
REQ-029 Output reset values: all outputs 0 (din_ready 0, busy 0, dout 8'h00).

Reset
REQ-030 rst_n low asynchronously clears the state (to IDLE), R0..R7, the counters and all outputs, including mid-codeword.
REQ-031 After reset deassertion, no output activity occurs until start.

Structure
REQ-032 The shared package holds N, K, NPAR, the primitive polynomial constant, and generator coefficients G0..G7 as 8-bit constants.
REQ-033 Constant multiplies use the existing gf256mul sub-module, instantiated 8 times with b tied to Gi.
REQ-034 There is no other sub-module.

Verification
REQ-035 All-zero message, 247 bytes, contiguous -> 255 output bytes all 8'h00, with sop on byte 0 and eop on byte 254.
REQ-036 Message zero except last byte = 8'h01 -> parity bytes equal G7, G6, ..., G0 in order.
REQ-037 Random 247-byte message with random din_valid gaps -> output matches the software model, and the codeword feeds the existing decoder chain with zero syndromes and error_num = 0.
REQ-038 Start pulse at message byte 100, then a full new message -> the first codeword is discarded (no eop) and the second codeword is correct.
REQ-039 rst_n asserted during PARITY byte 3 -> all outputs 0 immediately, no further dout_valid until the next start.
REQ-040 din_valid held high through PARITY -> din_ready = 0 and the parity bytes are unaffected.
